// File: rtl/arith_pkg.sv
// arith_pkg: widths and state encoding shared by the arithmetic unit blocks.
package arith_pkg;
    localparam int D_W = 8;
    localparam int N_W = 2 * D_W;
    localparam int CNT_W = $clog2(N_W);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration, shifts in a dividend bit and trial-subtracts.
module div_step
    import arith_pkg::*;
(
    input  logic [D_W-1:0] p,
    input  logic           q_msb,
    input  logic [D_W-1:0] divisor,
    output logic [D_W-1:0] p_next,
    output logic           q_bit
);
    logic [D_W:0] t;
    assign t = {p, q_msb};
    assign q_bit = t >= {1'b0, divisor};
    // after a successful subtract the result is below divisor, so D_W bits suffice
    assign p_next = q_bit ? D_W'(t - {1'b0, divisor}) : t[D_W-1:0];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned N_W/D_W restoring divider, one quotient bit per clock,
// valid/ready on both sides.
module seq_restoring_divider
    import arith_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_zero
);
    state_t state;
    logic [CNT_W-1:0] count;
    logic [D_W-1:0] dvsr;
    logic [D_W-1:0] p_next;
    logic q_bit;
    logic accept;
    assign accept = in_valid && in_ready;
    // quotient doubles as the dividend shift register, remainder as the partial remainder
    div_step u_step (
        .p(remainder),
        .q_msb(quotient[N_W-1]),
        .divisor(dvsr),
        .p_next(p_next),
        .q_bit(q_bit)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            in_ready <= 1'b0;
            out_valid <= 1'b0;
            quotient <= '0;
            remainder <= '0;
            div_zero <= 1'b0;
            count <= '0;
            dvsr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        dvsr <= divisor;
                        count <= '0;
                        remainder <= '0;
                        if (divisor == '0) begin
                            state <= DONE;
                            out_valid <= 1'b1;
                            quotient <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            quotient <= dividend;
                            div_zero <= 1'b0;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    quotient <= {quotient[N_W-2:0], q_bit};
                    remainder <= p_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(N_W - 1)) begin
                        state <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        out_valid <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed vector table plus back-pressure, reset-abort
// and randomised golden-model checks for seq_restoring_divider.
module tb_seq_restoring_divider;
    import arith_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [N_W-1:0] dividend = '0;
    logic [D_W-1:0] divisor = '0;
    logic in_ready, out_valid, div_zero;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [N_W-1:0] a;
        logic [D_W-1:0] b;
        logic [N_W-1:0] q;
        logic [D_W-1:0] r;
        logic dz;
        int lat;
    } vec_t;
    vec_t vecs[10];
    always #5 clk = ~clk;
    seq_restoring_divider dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_zero(div_zero)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic start_div(input logic [N_W-1:0] a, input logic [D_W-1:0] b);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 1);
        dividend = a;
        divisor = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask
    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_valid", 32'(out_valid), 0);
    endtask
    task automatic run_check(input string tag, input logic [N_W-1:0] a, input logic [D_W-1:0] b,
                             input logic [N_W-1:0] q, input logic [D_W-1:0] r, input logic dz);
        int lat;
        start_div(a, b);
        wait_done(lat);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_q"}, 32'(quotient), 32'(q));
        chk({tag, "_r"}, 32'(remainder), 32'(r));
        chk({tag, "_dz"}, 32'(div_zero), 32'(dz));
        drain();
    endtask
    initial begin
        int lat;
        logic [N_W-1:0] ra;
        logic [D_W-1:0] rb;
        vecs[0] = '{16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16};
        vecs[1] = '{16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16};
        vecs[2] = '{16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 16};
        vecs[3] = '{16'd5, 8'd200, 16'd0, 8'd5, 1'b0, 16};
        vecs[4] = '{16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 0};
        vecs[5] = '{16'd0, 8'd9, 16'd0, 8'd0, 1'b0, 16};
        vecs[6] = '{16'd300, 8'd17, 16'd17, 8'd11, 1'b0, 16};
        vecs[7] = '{16'd255, 8'd255, 16'd1, 8'd0, 1'b0, 16};
        vecs[8] = '{16'd65535, 8'd2, 16'd32767, 8'd1, 1'b0, 16};
        vecs[9] = '{16'd60000, 8'd13, 16'd4615, 8'd5, 1'b0, 16};
        #12;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_q", 32'(quotient), 0);
        chk("rst_r", 32'(remainder), 0);
        chk("rst_dz", 32'(div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 10; i++) begin
            start_div(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy", i), 32'(in_ready), 0);
            wait_done(lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_q", i), 32'(quotient), 32'(vecs[i].q));
            chk($sformatf("v%0d_r", i), 32'(remainder), 32'(vecs[i].r));
            chk($sformatf("v%0d_dz", i), 32'(div_zero), 32'(vecs[i].dz));
            drain();
            chk($sformatf("v%0d_hold_q", i), 32'(quotient), 32'(vecs[i].q));
            chk($sformatf("v%0d_idle", i), 32'(in_ready), 1);
        end
        // back-pressure: result must hold and new requests be ignored
        start_div(16'd1000, 8'd7);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'd5;
            divisor = 8'd1;
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_q", 32'(quotient), 142);
            chk("bp_r", 32'(remainder), 6);
        end
        in_valid = 1'b0;
        drain();
        chk("bp_after_q", 32'(quotient), 142);
        // reset in the middle of an operation
        start_div(16'd1000, 8'd7);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_q", 32'(quotient), 0);
        chk("mid_rst_r", 32'(remainder), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_in_ready", 32'(in_ready), 1);
        run_check("post_rst", 16'd60000, 8'd13, 16'd4615, 8'd5, 1'b0);
        for (int i = 0; i < 300; i++) begin
            ra = N_W'($urandom);
            rb = D_W'($urandom_range(0, 255));
            if (rb == 0) run_check("rnd_z", ra, rb, '1, '0, 1'b1);
            else run_check("rnd", ra, rb, ra / {8'b0, rb}, D_W'(ra % {8'b0, rb}), 1'b0);
        end
        for (int i = 0; i < 200; i++) begin
            ra = N_W'($urandom_range(0, 255));
            rb = D_W'($urandom_range(1, 255));
            run_check("prod", ra * {8'b0, rb}, rb, ra, '0, 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
